writeback_unit: RTL

- Write-side driver for the 32x32 integer register file.
- Collects results from the single-cycle ALU path and the variable-latency load path, and buffers load returns in a small FIFO.
- Arbitrates them onto the register file's single write port (wr_en/rd/result).
- Keeps a per-register pending scoreboard so decode can stall on RAW/WAW hazards.

---
 rtl/writeback_unit.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/writeback_unit.sv
// Register-file write-side driver: arbitrates ALU results and buffered load returns
// onto the single write port and tracks pending destinations. Optional forwarding via WB_BYPASS_EN.
module writeback_unit #(
    parameter int LD_DEPTH = 4,
    parameter int XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_result,
    input  logic            ld_valid,
    input  logic [4:0]      ld_rd,
    input  logic [XLEN-1:0] ld_data,
    output logic            ld_ready,
`ifdef WB_BYPASS_EN
    output logic            fwd_valid,
    output logic [4:0]      fwd_rd,
    output logic [XLEN-1:0] fwd_data,
`endif
    output logic            wr_en,
    output logic [31:0]     rd,
    output logic [XLEN-1:0] result,
    output logic [31:0]     busy,
    output logic            issue_err
);

    localparam int PW = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(LD_DEPTH);

    logic [XLEN+4:0] fifo_mem [LD_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    logic            alu_sel;
    logic            fifo_pop;
    logic            fifo_push;
    logic            sel_valid;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;
    logic [4:0]      rd_q;
    logic [31:0]     set_mask;
    logic [31:0]     clr_mask;
    logic            waw_hit;

    assign ld_ready  = (count != FULL_COUNT);
    assign fifo_push = ld_valid && ld_ready && (ld_rd != 5'd0);
    assign alu_sel   = alu_valid && (alu_rd != 5'd0);
    assign fifo_pop  = !alu_sel && (count != '0);

    // The ALU wins the write port; an x0 ALU result leaves the slot free for the FIFO head.
    always_comb begin
        sel_valid = 1'b0;
        sel_rd    = 5'd0;
        sel_data  = '0;
        if (alu_sel) begin
            sel_valid = 1'b1;
            sel_rd    = alu_rd;
            sel_data  = alu_result;
        end else if (fifo_pop) begin
            sel_valid = 1'b1;
            sel_rd    = fifo_mem[rd_ptr][XLEN+4:XLEN];
            sel_data  = fifo_mem[rd_ptr][XLEN-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr] <= {ld_rd, ld_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (fifo_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({fifo_push, fifo_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // rd/result keep their last value on idle cycles; only wr_en drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en  <= 1'b0;
            rd_q   <= 5'd0;
            result <= '0;
        end else begin
            wr_en <= sel_valid;
            if (sel_valid) begin
                rd_q   <= sel_rd;
                result <= sel_data;
            end
        end
    end

    assign rd = {27'd0, rd_q};

    assign waw_hit = issue_valid && (issue_rd != 5'd0) && busy[issue_rd];

    // A legal issue and a write to the same register in one cycle leaves it pending.
    always_comb begin
        set_mask = 32'd0;
        clr_mask = 32'd0;
        if (issue_valid && (issue_rd != 5'd0) && !busy[issue_rd]) begin
            set_mask[issue_rd] = 1'b1;
        end
        if (sel_valid) begin
            clr_mask[sel_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= 32'd0;
            issue_err <= 1'b0;
        end else begin
            busy      <= ((busy & ~clr_mask) | set_mask) & 32'hFFFF_FFFE;
            issue_err <= waw_hit;
        end
    end

`ifdef WB_BYPASS_EN
    assign fwd_valid = sel_valid && !rst;
    assign fwd_rd    = rst ? 5'd0 : sel_rd;
    assign fwd_data  = rst ? '0 : sel_data;
`endif

endmodule
